// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target with a 256 x 8 register file at a fixed 7-bit device address.
// Supports burst writes, two-phase reads, and reports every register write on a strobe.
module sccb_target_regfile #(
    parameter logic [6:0]  DEV7        = 7'h21,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_t_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        StIdle, StDev, StDevAck, StReg, StRegAck,
        StWdata, StWdataAck, StRdata, StRdAck, StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, ptr_q;
    logic       rw_q, sda_t_q, busy_q, wr_valid_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic [7:0] regs_q [256];
    logic [7:0] rx_byte, rd_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    assign rd_byte   = regs_q[ptr_q];

    // Synchronizers reset to the idle bus level so reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            rw_q       <= 1'b0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_det) begin
                state_q   <= StDev;
                bit_cnt_q <= 3'd0;
                sda_t_q   <= 1'b1;
            end else if (stop_det) begin
                state_q <= StIdle;
                sda_t_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StDev, StReg, StWdata: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == StDev) begin
                                    rw_q    <= rx_byte[0];
                                    busy_q  <= (rx_byte[7:1] == DEV7);
                                    state_q <= (rx_byte[7:1] == DEV7) ? StDevAck : StIgnore;
                                end else if (state_q == StReg) begin
                                    ptr_q   <= rx_byte;
                                    state_q <= StRegAck;
                                end else begin
                                    regs_q[ptr_q] <= rx_byte;
                                    wr_valid_q    <= 1'b1;
                                    wr_addr_q     <= ptr_q;
                                    wr_data_q     <= rx_byte;
                                    ptr_q         <= ptr_q + 8'd1;
                                    state_q       <= StWdataAck;
                                end
                            end
                        end
                    end
                    StDevAck, StRegAck, StWdataAck: begin
                        // First falling edge pulls SDA low, the second one ends the slot.
                        if (scl_fall) begin
                            if (sda_t_q) begin
                                sda_t_q <= 1'b0;
                            end else begin
                                bit_cnt_q <= 3'd0;
                                if (state_q == StDevAck && rw_q) begin
                                    shift_q <= {rd_byte[6:0], 1'b1};
                                    sda_t_q <= rd_byte[7];
                                    state_q <= StRdata;
                                end else begin
                                    sda_t_q <= 1'b1;
                                    state_q <= (state_q == StDevAck) ? StReg : StWdata;
                                end
                            end
                        end
                    end
                    StRdata: begin
                        if (scl_fall) begin
                            sda_t_q <= shift_q[7];
                            shift_q <= {shift_q[6:0], 1'b1};
                        end else if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= StRdAck;
                        end
                    end
                    StRdAck: begin
                        // Release waits for SCL low so letting go of a 0 bit never looks like STOP.
                        if (scl_fall) begin
                            sda_t_q <= 1'b1;
                        end else if (scl_rise) begin
                            ptr_q <= ptr_q + 8'd1;
                            if (!sda_s) begin
                                shift_q   <= regs_q[ptr_q + 8'd1];
                                bit_cnt_q <= 3'd0;
                                state_q   <= StRdata;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    default: sda_t_q <= 1'b1;
                endcase
            end
        end
    end

    assign sda_t_o    = sda_t_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Directed bench for sccb_target_regfile: a bit-banged bus master drives
// write, read, repeated-START and reset scenarios against hand-computed values.
module tb_sccb_target_regfile;

    localparam int Q = 80;  // quarter SCL period in ns (8 clocks)

    logic       clk = 1'b0;
    logic       reset, scl, sda_m;
    logic       sda_t, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;
    wire        sda_bus = sda_m & sda_t;

    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    int         base;
    logic [7:0] s_addr [16];
    logic [7:0] s_data [16];
    logic       low_seen = 1'b0;
    logic       ack;
    logic [7:0] d;

    sccb_target_regfile #(
        .DEV7       (7'h21),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_t_o   (sda_t),
        .wr_valid_o(wr_valid),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            s_addr[strobes[3:0]] = wr_addr;
            s_data[strobes[3:0]] = wr_data;
            strobes++;
        end
        if (!sda_t) low_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic wbit(input logic b);
        sda_m = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; #Q;
        scl = 1'b1;   #Q;
        b = sda_bus;  #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic wbyte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(a);
    endtask

    task automatic rbyte(output logic [7:0] v, input logic master_nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        wbit(master_nack);
        sda_m = 1'b1;
    endtask

    task automatic read_at(input logic [7:0] a, output logic [7:0] v);
        logic k;
        bus_start(); wbyte(8'h42, k); wbyte(a, k); bus_stop();
        bus_start(); wbyte(8'h43, k); rbyte(v, 1'b1); bus_stop();
    endtask

    initial begin
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("reset_sda_t", {7'd0, sda_t}, 8'h01);
        chk("reset_wr_valid", {7'd0, wr_valid}, 8'h00);
        chk("reset_wr_addr", wr_addr, 8'h00);
        chk("reset_wr_data", wr_data, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        #20;

        // Init-style write
        base = strobes;
        bus_start();
        wbyte(8'h42, ack); chk("init_ack_dev", {7'd0, ack}, 8'h00);
        chk("init_busy_during", {7'd0, busy}, 8'h01);
        wbyte(8'h12, ack); chk("init_ack_reg", {7'd0, ack}, 8'h00);
        wbyte(8'h80, ack); chk("init_ack_data", {7'd0, ack}, 8'h00);
        bus_stop(); #Q;
        chk("init_strobes", 8'(strobes - base), 8'd1);
        chk("init_wr_addr", s_addr[base[3:0]], 8'h12);
        chk("init_wr_data", s_data[base[3:0]], 8'h80);
        chk("init_busy_after", {7'd0, busy}, 8'h00);

        // Wrong address
        base = strobes;
        low_seen = 1'b0;
        bus_start();
        wbyte(8'h44, ack); chk("wrong_ack", {7'd0, ack}, 8'h01);
        chk("wrong_busy", {7'd0, busy}, 8'h00);
        wbyte(8'h12, ack);
        wbyte(8'h80, ack);
        bus_stop(); #Q;
        chk("wrong_sda_low_seen", {7'd0, low_seen}, 8'h00);
        chk("wrong_strobes", 8'(strobes - base), 8'd0);

        // Burst write with pointer wrap
        base = strobes;
        bus_start();
        wbyte(8'h42, ack);
        wbyte(8'hFE, ack);
        wbyte(8'hA1, ack); chk("burst_ack0", {7'd0, ack}, 8'h00);
        wbyte(8'hB2, ack); chk("burst_ack1", {7'd0, ack}, 8'h00);
        wbyte(8'hC3, ack); chk("burst_ack2", {7'd0, ack}, 8'h00);
        bus_stop(); #Q;
        chk("burst_strobes", 8'(strobes - base), 8'd3);
        chk("burst_addr0", s_addr[4'(base)], 8'hFE);
        chk("burst_addr1", s_addr[4'(base + 1)], 8'hFF);
        chk("burst_addr2", s_addr[4'(base + 2)], 8'h00);
        chk("burst_data0", s_data[4'(base)], 8'hA1);
        chk("burst_data1", s_data[4'(base + 1)], 8'hB2);
        chk("burst_data2", s_data[4'(base + 2)], 8'hC3);

        // Two-phase read with master ACK then NACK
        bus_start(); wbyte(8'h42, ack); wbyte(8'h3A, ack); wbyte(8'h04, ack); bus_stop();
        bus_start(); wbyte(8'h42, ack); wbyte(8'h3A, ack); bus_stop();
        bus_start();
        wbyte(8'h43, ack); chk("rd_ack_dev", {7'd0, ack}, 8'h00);
        rbyte(d, 1'b0); chk("rd_byte0", d, 8'h04);
        rbyte(d, 1'b1); chk("rd_byte1", d, 8'h00);
        chk("rd_released_after_nack", {7'd0, sda_t}, 8'h01);
        bus_stop(); #Q;
        chk("rd_busy_after", {7'd0, busy}, 8'h00);

        read_at(8'h00, d); chk("read_wrapped_reg00", d, 8'hC3);
        read_at(8'h12, d); chk("read_reg12_kept", d, 8'h80);

        // Repeated START in the middle of the register byte
        base = strobes;
        bus_start();
        wbyte(8'h42, ack);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        bus_start();
        wbyte(8'h42, ack); wbyte(8'h11, ack); wbyte(8'h01, ack);
        bus_stop(); #Q;
        chk("rstart_strobes", 8'(strobes - base), 8'd1);
        chk("rstart_addr", s_addr[base[3:0]], 8'h11);
        chk("rstart_data", s_data[base[3:0]], 8'h01);
        read_at(8'h11, d); chk("rstart_readback", d, 8'h01);

        // Reset while the target is driving a 0 bit in RDATA
        bus_start(); wbyte(8'h42, ack); wbyte(8'h3A, ack); bus_stop();
        bus_start();
        wbyte(8'h43, ack);
        chk("rst_pre_sda_low", {7'd0, sda_t}, 8'h00);
        chk("rst_pre_busy", {7'd0, busy}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_sda_t", {7'd0, sda_t}, 8'h01);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_wr_valid", {7'd0, wr_valid}, 8'h00);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        bus_stop();
        read_at(8'h11, d); chk("rst_regs_cleared", d, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
